// File: rtl/sap_ctrl_pkg.sv
// sap_ctrl_pkg: opcodes, FSM states and strobe vector shared by the SAP sequencer
package sap_ctrl_pkg;
  localparam int SAP_DATA_W = 8;
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LDA  = 3'd1;
  localparam logic [2:0] OP_LDB  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_OUT  = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_WRITE, S_OUTCAP, S_OUTWAIT, S_HALT
  } state_t;
  typedef struct packed {
    logic nla;
    logic nlb;
    logic ea;
    logic eb;
    logic eu;
    logic sub;
    logic imm_oe;
  } strobe_t;
  localparam strobe_t STROBE_OFF = 7'b1100000;
endpackage

// File: rtl/sap_ctrl_decode.sv
// sap_ctrl_decode: maps (state, op) to the datapath strobe vector
module sap_ctrl_decode
  import sap_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [2:0] op,
  output strobe_t    strobe
);
  // the load state drives the immediate; ALU states drive Eu; WRITE also loads A
  always_comb begin
    strobe = STROBE_OFF;
    strobe.imm_oe = state == S_LOAD;
    strobe.nla = !((state == S_LOAD && op != OP_LDB) || state == S_WRITE);
    strobe.nlb = !(state == S_LOAD && op == OP_LDB);
    strobe.eu = state == S_SETTLE || state == S_WRITE;
    strobe.sub = (state == S_SETTLE || state == S_WRITE) && op == OP_SUB;
    strobe.ea = state == S_OUTCAP;
  end
endmodule

// File: rtl/sap_ctrl_sequencer.sv
// sap_ctrl_sequencer: expands handshaked SAP instructions into timed datapath strobes
module sap_ctrl_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter int DATA_W     = SAP_DATA_W,
  parameter int ALU_SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              cf_in,
  input  logic              zf_in,
  output logic              imm_oe,
  output logic [DATA_W-1:0] imm_out,
  output logic              nLa,
  output logic              nLb,
  output logic              Ea,
  output logic              Eb,
  output logic              Eu,
  output logic              sub,
  output logic              cf,
  output logic              zf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              halted
);
  state_t state, state_n;
  logic [2:0] op_q, op_n, cnt;
  logic accept;
  strobe_t strobe_n, strobe_q;
  assign instr_ready = state == S_IDLE;
  assign busy = state != S_IDLE;
  assign halted = state == S_HALT;
  assign accept = instr_valid && instr_ready;
  assign op_n = accept ? instr_op : op_q;
  assign {nLa, nLb, Ea, Eb, Eu, sub, imm_oe} = strobe_q;
  // next-state selection; the op seen here is the one being accepted this cycle
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:
        if (accept)
          state_n = op_n == OP_NOP ? S_IDLE :
                    (op_n == OP_LDA || op_n == OP_LDB || op_n == OP_CLR) ? S_LOAD :
                    (op_n == OP_ADD || op_n == OP_SUB) ? S_SETTLE :
                    op_n == OP_OUT ? S_OUTCAP : S_HALT;
      S_LOAD:    state_n = S_IDLE;
      S_SETTLE:  state_n = cnt == 3'd0 ? S_WRITE : S_SETTLE;
      S_WRITE:   state_n = S_IDLE;
      S_OUTCAP:  state_n = S_OUTWAIT;
      S_OUTWAIT: state_n = out_ready ? S_IDLE : S_OUTWAIT;
      S_HALT:    state_n = S_HALT;
      default:   state_n = S_IDLE;
    endcase
  end
  sap_ctrl_decode u_decode (
    .state  (state_n),
    .op     (op_n),
    .strobe (strobe_n)
  );
  // state, op latch, settle down-counter and registered strobes (drop async on reset)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= OP_NOP;
      cnt      <= 3'd0;
      strobe_q <= STROBE_OFF;
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      strobe_q <= strobe_n;
      cnt      <= accept ? 3'(ALU_SETTLE - 1) : state == S_SETTLE ? cnt - 3'd1 : cnt;
    end
  end
  // immediate latch, flags captured at the end of WRITE, OUT capture and host handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_out   <= '0;
      cf        <= 1'b0;
      zf        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept && (instr_op == OP_LDA || instr_op == OP_LDB || instr_op == OP_CLR))
        imm_out <= instr_op == OP_CLR ? '0 : instr_imm;
      if (state == S_WRITE) begin
        cf <= cf_in;
        zf <= zf_in;
      end
      if (state == S_OUTCAP) begin
        out_data  <= bus_in;
        out_valid <= 1'b1;
      end else if (state == S_OUTWAIT && out_ready)
        out_valid <= 1'b0;
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({strobe_q.imm_oe, strobe_q.ea, strobe_q.eb, strobe_q.eu}));
endmodule

// File: tb/tb_sap_ctrl_sequencer.sv
// tb_sap_ctrl_sequencer: random and directed programs checked against an instruction-level model
module tb_sap_ctrl_sequencer;
  localparam int SETTLE = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic instr_valid = 1'b0, instr_ready;
  logic [2:0] instr_op = 3'd0;
  logic [7:0] instr_imm = 8'h00, bus, imm_out, out_data;
  logic cf_in, zf_in, imm_oe, nLa, nLb, Ea, Eb, Eu, sub, cf, zf;
  logic out_valid, out_ready = 1'b1, busy, halted;
  logic [7:0] ra = 8'h00, rb = 8'h00;
  logic [8:0] alu;
  int checks = 0, failures = 0;
  int c_nla, c_nlb, c_ea, c_eu, c_sub, c_imm, conflicts = 0;
  int ma = 0, mb = 0, mout = 0, mcf = 0, mzf = 0;

  always #5 clk = ~clk;

  sap_ctrl_sequencer #(.DATA_W(8), .ALU_SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_imm(instr_imm), .bus_in(bus), .cf_in(cf_in), .zf_in(zf_in),
    .imm_oe(imm_oe), .imm_out(imm_out), .nLa(nLa), .nLb(nLb), .Ea(Ea), .Eb(Eb), .Eu(Eu),
    .sub(sub), .cf(cf), .zf(zf), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .halted(halted)
  );

  assign alu = sub ? {1'b0, ra} + {1'b0, ~rb} + 9'd1 : {1'b0, ra} + {1'b0, rb};
  assign cf_in = alu[8];
  assign zf_in = alu[7:0] == 8'h00;
  assign bus = imm_oe ? imm_out : Ea ? ra : Eb ? rb : Eu ? alu[7:0] : 8'h00;

  always @(posedge clk) begin
    if (!nLa) ra <= bus;
    if (!nLb) rb <= bus;
  end

  always @(negedge clk) if (rst_n) begin
    if (!nLa) c_nla++;
    if (!nLb) c_nlb++;
    if (Ea) c_ea++;
    if (Eu) c_eu++;
    if (sub) c_sub++;
    if (imm_oe) c_imm++;
    if ($countones({imm_oe, Ea, Eb, Eu}) > 1) conflicts++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] imm, output int lat);
    int w = 0;
    while (!instr_ready && w < 50) begin @(negedge clk); w++; end
    c_nla = 0; c_nlb = 0; c_ea = 0; c_eu = 0; c_sub = 0; c_imm = 0;
    instr_valid = 1'b1;
    instr_op = op;
    instr_imm = imm;
    @(negedge clk);
    instr_valid = 1'b0;
    lat = 1;
    while (!instr_ready && lat < 50) begin
      instr_valid = 1'($urandom_range(0, 1));
      instr_op = 3'($urandom);
      instr_imm = 8'($urandom);
      @(negedge clk);
      lat++;
    end
    instr_valid = 1'b0;
  endtask

  task automatic run(input logic [2:0] op, input logic [7:0] imm);
    int lat, e_lat, e_nla, e_nlb, e_ea, e_eu, e_sub, e_imm;
    send(op, imm, lat);
    e_lat = 1; e_nla = 0; e_nlb = 0; e_ea = 0; e_eu = 0; e_sub = 0; e_imm = 0;
    case (op)
      3'd1: begin ma = imm; e_lat = 2; e_nla = 1; e_imm = 1; end
      3'd2: begin mb = imm; e_lat = 2; e_nlb = 1; e_imm = 1; end
      3'd3: begin
        mcf = (ma + mb) > 255 ? 1 : 0;
        ma = (ma + mb) % 256;
        mzf = ma == 0 ? 1 : 0;
        e_lat = SETTLE + 2; e_nla = 1; e_eu = SETTLE + 1;
      end
      3'd4: begin
        mcf = ma >= mb ? 1 : 0;
        ma = (ma + 256 - mb) % 256;
        mzf = ma == 0 ? 1 : 0;
        e_lat = SETTLE + 2; e_nla = 1; e_eu = SETTLE + 1; e_sub = SETTLE + 1;
      end
      3'd5: begin mout = ma; e_lat = 3; e_ea = 1; end
      3'd6: begin ma = 0; e_lat = 2; e_nla = 1; e_imm = 1; end
      default: ;
    endcase
    chk($sformatf("lat_op%0d", op), lat, e_lat);
    chk("nla_cycles", c_nla, e_nla);
    chk("nlb_cycles", c_nlb, e_nlb);
    chk("ea_cycles", c_ea, e_ea);
    chk("eu_cycles", c_eu, e_eu);
    chk("sub_cycles", c_sub, e_sub);
    chk("immoe_cycles", c_imm, e_imm);
    chk("reg_a", ra, ma);
    chk("reg_b", rb, mb);
    chk("cf", cf, mcf);
    chk("zf", zf, mzf);
    chk("out_data", out_data, mout);
    chk("out_valid_idle", out_valid, 0);
  endtask

  initial begin
    logic [7:0] ra_save;
    int lat;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {nLa, nLb, Ea, Eb, Eu, sub, imm_oe}, 7'b1100000);
    chk("rst_flags", {cf, zf}, 0);
    chk("rst_out", {out_valid, out_data}, 0);
    chk("rst_imm", imm_out, 0);
    chk("rst_halted", halted, 0);

    run(3'd1, 8'h0F); run(3'd2, 8'h01); run(3'd3, 8'h00); run(3'd5, 8'h00);
    chk("dir_out_0x10", out_data, 8'h10);
    run(3'd1, 8'hFF); run(3'd2, 8'h01); run(3'd3, 8'h00);
    chk("wrap_flags", {cf, zf}, 2'b11);

    run(3'd1, 8'h21); run(3'd2, 8'h42);
    instr_valid = 1'b1; instr_op = 3'd3;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("settle_eu", Eu, 1);
    ra_save = ra;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_nla", nLa, 1);
    chk("midrst_eu", Eu, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_flags", {cf, zf}, 0);
    chk("midrst_rega", ra, ra_save);
    rst_n = 1'b1;
    mcf = 0; mzf = 0; mout = 0;
    @(negedge clk);

    run(3'd1, 8'h05); run(3'd2, 8'h05); run(3'd4, 8'h00);
    chk("sub_zf", zf, 1);

    run(3'd1, 8'h3C);
    out_ready = 1'b0;
    instr_valid = 1'b1; instr_op = 3'd5;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("wait_valid", out_valid, 1);
      chk("wait_data", out_data, 8'h3C);
      chk("wait_ready", instr_ready, 0);
      instr_valid = 1'b1; instr_op = 3'd1;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("wait_release_ready", instr_ready, 1);
    chk("wait_release_valid", out_valid, 0);
    mout = 8'h3C;

    for (int i = 0; i < 150; i++) run(3'($urandom_range(0, 6)), 8'($urandom));

    send(3'd7, 8'h00, lat);
    for (int i = 0; i < 10; i++) begin
      chk("halt_ready", instr_ready, 0);
      chk("halt_flag", halted, 1);
      instr_valid = 1'b1; instr_op = 3'($urandom);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("halt_cleared", halted, 0);
    chk("halt_rst_ready", instr_ready, 1);
    chk("bus_onehot", conflicts, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
